// File: rtl/qoa_spi_master.sv
// SPI mode-0 master: byte-wide TX/RX handshake, MSB first, CS held across
// multi-byte bursts. Optional MOSI->MISO loopback under QOA_SPI_MASTER_LOOPBACK_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | cs_n high, waiting for first byte of a burst
// SETUP   | cs_n low, bit7 on mosi, one half-period before first rise
// SCK_HI  | sclk high; miso captured on the edge that ends the phase
// SCK_LO  | sclk low; next bit presented on mosi
// NEXT    | byte done, burst continues; cs_n low, waits for next byte
// CS_HOLD | last byte done; cs_n still low for one half-period
// CS_GAP  | cs_n high for one half-period before accepting a new burst
module qoa_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
`ifdef QOA_SPI_MASTER_LOOPBACK_EN
   ,
   input  logic       loopback
`endif
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SCK_LO  = 3'd2,
      SCK_HI  = 3'd3,
      NEXT    = 3'd4,
      CS_HOLD = 3'd5,
      CS_GAP  = 3'd6
   } state_e;

   state_e     state_q, state_nxt;
   logic [7:0] cnt_q, cnt_nxt;
   logic [2:0] bit_q, bit_nxt;
   logic [7:0] sh_q, sh_nxt;
   logic       last_q, last_nxt;
   logic [7:0] rx_data_nxt;
   logic       rx_valid_nxt;
   logic       in_bit;

   function automatic logic cs_active(input state_e s);
      return s inside {SETUP, SCK_LO, SCK_HI, NEXT, CS_HOLD};
   endfunction

   function automatic logic drive_mosi(input state_e s);
      return s inside {SETUP, SCK_LO, SCK_HI};
   endfunction

   // sh_q[7] is the bit currently on mosi, so loopback can tap it directly.
`ifdef QOA_SPI_MASTER_LOOPBACK_EN
   assign in_bit = loopback ? sh_q[7] : miso;
`else
   assign in_bit = miso;
`endif

   assign tx_ready = ((state_q == IDLE) || (state_q == NEXT)) && !rst;

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      bit_nxt      = bit_q;
      sh_nxt       = sh_q;
      last_nxt     = last_q;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               sh_nxt    = tx_data;
               last_nxt  = tx_last;
               bit_nxt   = 3'd0;
               cnt_nxt   = DIV_M1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == 8'd0) begin
               cnt_nxt   = DIV_M1;
               state_nxt = SCK_HI;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         SCK_HI: begin
            if (cnt_q == 8'd0) begin
               sh_nxt  = {sh_q[6:0], in_bit};
               bit_nxt = bit_q + 3'd1;
               cnt_nxt = DIV_M1;
               if (bit_q == 3'd7) begin
                  rx_data_nxt  = {sh_q[6:0], in_bit};
                  rx_valid_nxt = 1'b1;
                  state_nxt    = last_q ? CS_HOLD : NEXT;
               end else begin
                  state_nxt = SCK_LO;
               end
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         SCK_LO: begin
            if (cnt_q == 8'd0) begin
               cnt_nxt   = DIV_M1;
               state_nxt = SCK_HI;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         NEXT: begin
            // Entering SCK_LO keeps the low half-period before the next rise.
            if (tx_valid) begin
               sh_nxt    = tx_data;
               last_nxt  = tx_last;
               bit_nxt   = 3'd0;
               cnt_nxt   = DIV_M1;
               state_nxt = SCK_LO;
            end
         end
         CS_HOLD: begin
            if (cnt_q == 8'd0) begin
               cnt_nxt   = DIV_M1;
               state_nxt = CS_GAP;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         CS_GAP: begin
            if (cnt_q == 8'd0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so they stay glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         bit_q    <= 3'd0;
         sh_q     <= 8'd0;
         last_q   <= 1'b0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         sclk     <= 1'b0;
         cs_n     <= 1'b1;
         busy     <= 1'b0;
         mosi     <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         bit_q    <= bit_nxt;
         sh_q     <= sh_nxt;
         last_q   <= last_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         sclk     <= (state_nxt == SCK_HI);
         cs_n     <= !cs_active(state_nxt);
         busy     <= cs_active(state_nxt);
         mosi     <= drive_mosi(state_nxt) ? sh_nxt[7] : 1'b0;
      end
   end

endmodule

// File: doc/qoa_spi_master.md
QOA_SPI_MASTER -- requirements
Module: qoa_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have one clock and synchronous active-high reset; ports in order below.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to send, MSB first.
REQ-006 tx_valid  input  1  tx_data valid.
REQ-007 tx_last  input  1  with tx_data: deassert CS after this byte.
REQ-008 tx_ready  output  1  byte accepted on the cycle where tx_valid&tx_ready.
REQ-009 rx_data  output  8  byte captured from MISO, MSB first.
REQ-010 rx_valid  output  1  one-cycle pulse; rx_data valid.
REQ-011 busy  output  1  high whenever cs_n low or CS_HOLD active.
REQ-012 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-013 mosi  output  1  serial data out.
REQ-014 miso  input  1  serial data in; externally synchronous to clk.
REQ-015 cs_n  output  1  chip select, active low.

Function
REQ-016 SHALL implement FSM IDLE, SETUP, SCK_LO, SCK_HI, NEXT, CS_HOLD, CS_GAP.
REQ-017 IDLE: tx_ready=1; on tx_valid load shift register and tx_last, go SETUP.
REQ-018 SETUP: cs_n=0, sclk=0, mosi=bit7, CLK_DIV cycles, then SCK_HI.
REQ-019 SCK_HI: sclk=1 for CLK_DIV cycles; miso sampled on the clk edge ending the phase.
REQ-020 SCK_LO: sclk=0, mosi=next bit (changes on falling SCLK), CLK_DIV cycles, then SCK_HI.
REQ-021 After 8th SCK_HI: sclk=0, rx_valid=1 for exactly one cycle, rx_data updated same cycle.
REQ-022 First byte: rx_valid asserts exactly 2*8*CLK_DIV cycles after cs_n falls.
REQ-023 Byte with tx_last=0 -> NEXT: cs_n stays 0, sclk 0, tx_ready=1; stall indefinitely until tx_valid.
REQ-024 NEXT with tx_valid: load byte, mosi=bit7, go SCK_LO (CLK_DIV low cycles before next rise); no extra SCLK edges.
REQ-025 Byte with tx_last=1 -> CS_HOLD: cs_n=0 for CLK_DIV cycles, then CS_GAP: cs_n=1 for CLK_DIV cycles, then IDLE.
REQ-026 tx_ready SHALL be 0 in SETUP, SCK_LO, SCK_HI, CS_HOLD, CS_GAP.
REQ-027 tx_data/tx_last sampled only at acceptance; later changes SHALL not affect the byte in flight.
REQ-028 rx_data SHALL hold its value until the next rx_valid.
REQ-029 Half-period counter SHALL be 8-bit, reload CLK_DIV-1, no wrap beyond that.

Reset
REQ-030 rst SHALL force, next edge: state IDLE, cs_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0.
REQ-031 Reset mid-byte SHALL abort with no rx_valid; tx_ready=1 on first cycle after rst drops.
REQ-032 rst SHALL dominate tx_valid in the same cycle.

Configuration
REQ-033 Macro QOA_SPI_MASTER_LOOPBACK_EN SHALL add input loopback (1 bit, last port).
REQ-034 With macro and loopback=1: shift register samples internal mosi instead of miso; pins unchanged.
REQ-035 Without macro: no loopback port; miso always used.

Verification (CLK_DIV=2 unless stated)
REQ-036 tx 0xA5 last=1, miso tied 0 -> mosi 1,0,1,0,0,1,0,1 on 8 sclk rises; rx_data=0x00; rx_valid 32 cycles after cs_n fall; cs_n high 2 cycles later.
REQ-037 Slave model echoing 0x3C, tx 0xFF last=1 -> rx_data=0x3C, exactly 8 sclk rising edges.
REQ-038 Two bytes 0x12 (last=0), 0x34 (last=1) with tx_valid delayed 10 cycles -> cs_n low continuously, sclk low during stall, 16 rises total.
REQ-039 rst after 3rd sclk rise -> next cycle cs_n=1, sclk=0, no rx_valid; new byte 0x81 afterwards completes normally.
REQ-040 QOA_SPI_MASTER_LOOPBACK_EN defined, loopback=1, CLK_DIV=1, tx 0xC3 -> rx_data=0xC3 after 16 cycles.
